// File: rtl/comm_link_pkg.sv
// comm_link_pkg: shared state encodings, sync nibbles and field positions of the
// board-to-board link.
package comm_link_pkg;

    typedef enum logic [2:0] {T_IDLE, T_SETUP, T_STROBE, T_RELEASE, T_DONE} tx_state_e;
    typedef enum logic [1:0] {R_IDLE, R_WAITLOW, R_DELIVER, R_ACKLOW} rx_state_e;

    localparam logic [3:0] SYNC_MASTER = 4'hA;
    localparam logic [3:0] SYNC_SLAVE  = 4'h5;

    localparam int DATA_LSB     = 0;
    localparam int DATA_MSB     = 3;
    localparam int STROBE_BIT   = 4;
    localparam int ACK_BIT      = 5;
    localparam int TX_REQ_BIT   = 4;
    localparam int RX_ACK_BIT   = 5;
    localparam int TX_DONE_BIT  = 4;
    localparam int RX_VALID_BIT = 5;

endpackage

// File: rtl/comm_link_sync.sv
// comm_link_sync: WIDTH-bit, STAGES-deep flop chain bringing the peer's wires into
// the local clock domain.
module comm_link_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/comm_link.sv
// comm_link: full-duplex 4-phase nibble link between two boards, with a one-time
// master/slave sync exchange, TX stall timeout and link status.
module comm_link
    import comm_link_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic       masterslave_ismaster,
    input  logic [5:0] sys_tx,
    output logic [5:0] sys_rx,
    output logic [5:0] link_out,
    input  logic [5:0] link_in,
    output logic       link_up,
    output logic       link_err
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    tx_state_e tx_q, tx_d;
    rx_state_e rx_q, rx_d;
    logic [3:0]    tx_data_q, tx_data_d, cap_q, cap_d, dout_q, dout_d;
    logic          is_sync_q, is_sync_d, sync_sent_q, sync_sent_d, reply_q, reply_d;
    logic          up_q, up_d, err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [5:0]    link_s;
    logic          peer_strobe, peer_ack, counting, timeout, sync_go;
    logic [3:0]    sync_val;

    comm_link_sync #(.WIDTH(6), .STAGES(SYNC_STAGES)) u_sync (
        .clk_i  (clk_clk),
        .rst_ni (reset_reset_n),
        .d_i    (link_in),
        .q_o    (link_s)
    );

    assign peer_strobe = link_s[STROBE_BIT];
    assign peer_ack    = link_s[ACK_BIT];
    assign counting    = (tx_q == T_STROBE) || (tx_q == T_RELEASE);
    assign timeout     = counting && (cnt_q == CW'(TIMEOUT_CYCLES));
    assign sync_go     = !err_q && ((masterslave_ismaster && !sync_sent_q) || reply_q);
    assign sync_val    = masterslave_ismaster ? SYNC_MASTER : SYNC_SLAVE;

    always_comb begin
        tx_d        = tx_q;
        rx_d        = rx_q;
        tx_data_d   = tx_data_q;
        cap_d       = cap_q;
        dout_d      = dout_q;
        is_sync_d   = is_sync_q;
        sync_sent_d = sync_sent_q;
        reply_d     = reply_q;
        up_d        = up_q;
        err_d       = err_q;
        case (tx_q)
            T_IDLE: begin
                if (sync_go) begin
                    tx_d        = T_SETUP;
                    tx_data_d   = sync_val;
                    is_sync_d   = 1'b1;
                    sync_sent_d = 1'b1;
                    reply_d     = 1'b0;
                end else if (up_q && sys_tx[TX_REQ_BIT]) begin
                    tx_d      = T_SETUP;
                    tx_data_d = sys_tx[DATA_MSB:DATA_LSB];
                    is_sync_d = 1'b0;
                end
            end
            T_SETUP:   tx_d = T_STROBE;
            T_STROBE:  tx_d = peer_ack ? T_RELEASE : T_STROBE;
            T_RELEASE: begin
                if (!peer_ack) begin
                    tx_d = is_sync_q ? T_IDLE : T_DONE;
                    // The slave's link comes up once its reply has been fully handshaken
                    if (is_sync_q && !masterslave_ismaster && !err_q) up_d = 1'b1;
                end
            end
            T_DONE:    tx_d = sys_tx[TX_REQ_BIT] ? T_DONE : T_IDLE;
            default:   tx_d = T_IDLE;
        endcase
        case (rx_q)
            R_IDLE: begin
                if (peer_strobe) begin
                    rx_d  = R_WAITLOW;
                    cap_d = link_s[DATA_MSB:DATA_LSB];
                end
            end
            R_WAITLOW: begin
                if (!peer_strobe) begin
                    rx_d   = up_q ? R_DELIVER : R_IDLE;
                    dout_d = up_q ? cap_q : dout_q;
                    if (!up_q && !err_q) begin
                        if (masterslave_ismaster && cap_q == SYNC_SLAVE) up_d = 1'b1;
                        if (!masterslave_ismaster && cap_q == SYNC_MASTER) reply_d = 1'b1;
                    end
                end
            end
            R_DELIVER: rx_d = sys_tx[RX_ACK_BIT] ? R_ACKLOW : R_DELIVER;
            R_ACKLOW:  rx_d = sys_tx[RX_ACK_BIT] ? R_ACKLOW : R_IDLE;
            default:   rx_d = R_IDLE;
        endcase
        if (timeout) begin
            tx_d  = T_IDLE;
            err_d = 1'b1;
            up_d  = 1'b0;
        end
        cnt_d = (tx_d != tx_q) ? '0 : counting ? cnt_q + CW'(1) : cnt_q;
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            tx_q        <= T_IDLE;
            rx_q        <= R_IDLE;
            tx_data_q   <= '0;
            cap_q       <= '0;
            dout_q      <= '0;
            is_sync_q   <= 1'b0;
            sync_sent_q <= 1'b0;
            reply_q     <= 1'b0;
            up_q        <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            tx_data_q   <= tx_data_d;
            cap_q       <= cap_d;
            dout_q      <= dout_d;
            is_sync_q   <= is_sync_d;
            sync_sent_q <= sync_sent_d;
            reply_q     <= reply_d;
            up_q        <= up_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign link_out = {rx_q == R_WAITLOW, tx_q == T_STROBE, tx_data_q};
    assign sys_rx   = {rx_q == R_DELIVER, tx_q == T_DONE, dout_q};
    assign link_up  = up_q;
    assign link_err = err_q;

endmodule

// File: tb/tb_comm_link.sv
// tb_comm_link: master/slave pair cross-connected plus a lone master with a dead peer.
module tb_comm_link;

    logic       clk = 1'b0;
    logic       rst_m_n, rst_s_n, rst_d_n;
    logic [5:0] mtx, stx, dtx, mrx, srx, drx, m2s, s2m, dlo;
    logic       m_up, s_up, d_up, m_err, s_err, d_err;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    comm_link #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(300)) u_m (
        .clk_clk(clk), .reset_reset_n(rst_m_n), .masterslave_ismaster(1'b1),
        .sys_tx(mtx), .sys_rx(mrx), .link_out(m2s), .link_in(s2m),
        .link_up(m_up), .link_err(m_err)
    );

    comm_link #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(300)) u_s (
        .clk_clk(clk), .reset_reset_n(rst_s_n), .masterslave_ismaster(1'b0),
        .sys_tx(stx), .sys_rx(srx), .link_out(s2m), .link_in(m2s),
        .link_up(s_up), .link_err(s_err)
    );

    comm_link #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(100)) u_d (
        .clk_clk(clk), .reset_reset_n(rst_d_n), .masterslave_ismaster(1'b1),
        .sys_tx(dtx), .sys_rx(drx), .link_out(dlo), .link_in(6'b0),
        .link_up(d_up), .link_err(d_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Plays the processor on both pair sides: releases tx_req after tx_done and
    // acknowledges every delivered nibble, recording what each side received.
    task automatic run_procs(input int n, output logic [3:0] m_got, output logic [3:0] s_got,
                             output int m_cnt, output int s_cnt);
        m_got = 4'h0; s_got = 4'h0; m_cnt = 0; s_cnt = 0;
        for (int i = 0; i < n; i++) begin
            if (mrx[5] && !mtx[5]) begin m_got = mrx[3:0]; m_cnt++; end
            if (srx[5] && !stx[5]) begin s_got = srx[3:0]; s_cnt++; end
            if (mrx[4]) mtx[4] = 1'b0;
            if (srx[4]) stx[4] = 1'b0;
            mtx[5] = mrx[5];
            stx[5] = srx[5];
            tick();
        end
    endtask

    task automatic test_reset();
        rst_m_n = 0; rst_s_n = 0; rst_d_n = 0;
        mtx = '0; stx = '0; dtx = '0;
        repeat (3) tick();
        checks++; if ({m2s, mrx} !== 12'h0) begin errors++; $display("FAIL reset_master_out got=%h exp=000", {m2s, mrx}); end
        checks++; if ({s2m, srx} !== 12'h0) begin errors++; $display("FAIL reset_slave_out got=%h exp=000", {s2m, srx}); end
        checks++; if ({m_up, m_err, s_up, s_err, d_up, d_err, dlo} !== 12'h0) begin
            errors++; $display("FAIL reset_status got=%b exp=0", {m_up, m_err, s_up, s_err, d_up, d_err, dlo}); end
    endtask

    task automatic test_sync();
        int rx_seen = 0;
        int n = 0;
        rst_m_n = 1; rst_s_n = 1;
        while (!(m_up && s_up) && n < 200) begin
            tick();
            n++;
            if (mrx[5] || srx[5] || mrx[4] || srx[4]) rx_seen++;
        end
        checks++; if ({m_up, s_up} !== 2'b11) begin errors++; $display("FAIL sync_link_up got=%b exp=11", {m_up, s_up}); end
        checks++; if (rx_seen != 0) begin errors++; $display("FAIL sync_sys_rx_quiet got=%0d exp=0", rx_seen); end
        repeat (6) tick();
        checks++; if ({m_err, s_err, mrx, srx} !== 14'h0) begin
            errors++; $display("FAIL sync_after got=%h exp=0", {m_err, s_err, mrx, srx}); end
    endtask

    task automatic test_single();
        logic [5:0] mo [1:16];
        logic [5:0] so [1:16];
        logic [5:0] sr [1:16];
        logic [5:0] mr [1:16];
        int f_data = 0, f_stb = 0, f_ack = 0, f_low = 0, f_val = 0, f_done = 0;
        mtx = {2'b01, 4'h3};
        for (int k = 1; k <= 16; k++) begin
            tick();
            mo[k] = m2s; so[k] = s2m; sr[k] = srx; mr[k] = mrx;
        end
        for (int k = 1; k <= 16; k++) begin
            if (f_data == 0 && mo[k][3:0] == 4'h3) f_data = k;
            if (f_stb != 0 && f_low == 0 && !mo[k][4]) f_low = k;
            if (f_stb == 0 && mo[k][4]) f_stb = k;
            if (f_ack == 0 && so[k][5]) f_ack = k;
            if (f_val == 0 && sr[k][5]) f_val = k;
            if (f_done == 0 && mr[k][4]) f_done = k;
        end
        checks++; if (f_data != 1) begin errors++; $display("FAIL single_data_cycle got=%0d exp=1", f_data); end
        checks++; if (f_stb != 2) begin errors++; $display("FAIL single_strobe_cycle got=%0d exp=2", f_stb); end
        checks++; if (f_ack != 5) begin errors++; $display("FAIL single_ack_cycle got=%0d exp=5", f_ack); end
        checks++; if (f_low != 8) begin errors++; $display("FAIL single_strobe_low_cycle got=%0d exp=8", f_low); end
        checks++; if (f_val != 11) begin errors++; $display("FAIL single_rx_valid_cycle got=%0d exp=11", f_val); end
        checks++; if (sr[11][3:0] !== 4'h3) begin errors++; $display("FAIL single_rx_data got=%h exp=3", sr[11][3:0]); end
        checks++; if (f_done != 14) begin errors++; $display("FAIL single_tx_done_cycle got=%0d exp=14", f_done); end
        mtx[4] = 1'b0;
        tick();
        checks++; if (mrx[4] !== 1'b0) begin errors++; $display("FAIL single_tx_done_fall got=%b exp=0", mrx[4]); end
        stx[5] = 1'b1;
        tick();
        checks++; if (srx[5] !== 1'b0) begin errors++; $display("FAIL single_rx_valid_fall got=%b exp=0", srx[5]); end
        stx[5] = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_duplex();
        logic [3:0] mg, sg;
        int mc, sc;
        mtx = {2'b01, 4'h7};
        stx = {2'b01, 4'hC};
        run_procs(60, mg, sg, mc, sc);
        checks++; if (sg !== 4'h7 || sc != 1) begin errors++; $display("FAIL duplex_slave_rx got=%h/%0d exp=7/1", sg, sc); end
        checks++; if (mg !== 4'hC || mc != 1) begin errors++; $display("FAIL duplex_master_rx got=%h/%0d exp=c/1", mg, mc); end
    endtask

    task automatic test_backpressure();
        int n = 0;
        int bad = 0;
        mtx = {2'b01, 4'h1};
        while (!mrx[4] && n < 40) begin tick(); n++; end
        mtx[4] = 1'b0;
        repeat (2) tick();
        checks++; if (srx !== {2'b10, 4'h1}) begin errors++; $display("FAIL bp_first_held got=%h exp=21", srx); end
        mtx = {2'b01, 4'h2};
        for (int i = 0; i < 100; i++) begin
            tick();
            if (s2m[5] || srx !== {2'b10, 4'h1}) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL bp_second_not_acked got=%0d exp=0", bad); end
        checks++; if (m2s[4] !== 1'b1) begin errors++; $display("FAIL bp_master_strobing got=%b exp=1", m2s[4]); end
        stx[5] = 1'b1;
        tick();
        checks++; if (srx[5] !== 1'b0) begin errors++; $display("FAIL bp_rx_valid_fall got=%b exp=0", srx[5]); end
        stx[5] = 1'b0;
        n = 0;
        while (!srx[5] && n < 40) begin tick(); n++; end
        checks++; if (srx !== {2'b10, 4'h2}) begin errors++; $display("FAIL bp_second_delivered got=%h exp=22", srx); end
        begin
            logic [3:0] mg, sg;
            int mc, sc;
            run_procs(40, mg, sg, mc, sc);
        end
        checks++; if ({m_err, m_up} !== 2'b01) begin errors++; $display("FAIL bp_link_ok got=%b exp=01", {m_err, m_up}); end
    endtask

    task automatic test_sync_values();
        logic [3:0] mg, sg;
        int mc, sc;
        mtx = {2'b01, 4'hA};
        run_procs(40, mg, sg, mc, sc);
        checks++; if (sg !== 4'hA || sc != 1) begin errors++; $display("FAIL syncval_a_as_data got=%h/%0d exp=a/1", sg, sc); end
        stx = {2'b01, 4'h5};
        run_procs(40, mg, sg, mc, sc);
        checks++; if (mg !== 4'h5 || mc != 1) begin errors++; $display("FAIL syncval_5_as_data got=%h/%0d exp=5/1", mg, mc); end
        checks++; if ({m_up, s_up, m_err, s_err} !== 4'b1100) begin
            errors++; $display("FAIL syncval_status got=%b exp=1100", {m_up, s_up, m_err, s_err}); end
    endtask

    task automatic test_dead_peer();
        int f_err = 0;
        logic stb50 = 1'b0;
        logic stb_at = 1'b1;
        int bad = 0;
        rst_d_n = 1;
        for (int k = 1; k <= 200; k++) begin
            tick();
            if (k == 50) stb50 = dlo[4];
            if (f_err == 0 && d_err) begin f_err = k; stb_at = dlo[4]; end
        end
        checks++; if (stb50 !== 1'b1) begin errors++; $display("FAIL dead_strobe_pending got=%b exp=1", stb50); end
        checks++; if (f_err != 103) begin errors++; $display("FAIL dead_err_cycle got=%0d exp=103", f_err); end
        checks++; if (stb_at !== 1'b0 || d_up !== 1'b0) begin errors++; $display("FAIL dead_strobe_up got=%b%b exp=00", stb_at, d_up); end
        dtx = {2'b01, 4'hF};
        for (int i = 0; i < 20; i++) begin
            tick();
            if (dlo !== {2'b00, 4'hA} || drx[4] || !d_err) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL dead_tx_req_ignored got=%0d exp=0", bad); end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        mtx = {2'b01, 4'h6};
        stx = {2'b01, 4'h9};
        while (!m2s[4] && n < 20) begin tick(); n++; end
        checks++; if (m2s[4] !== 1'b1) begin errors++; $display("FAIL mid_strobe_seen got=%b exp=1", m2s[4]); end
        rst_m_n = 0;
        tick();
        checks++; if ({m2s, mrx, m_up} !== 13'h0) begin errors++; $display("FAIL mid_reset_out got=%h exp=0", {m2s, mrx, m_up}); end
        n = 0;
        while (!s_err && n < 400) begin tick(); n++; end
        checks++; if ({s_err, s_up, s2m[4]} !== 3'b100) begin
            errors++; $display("FAIL mid_peer_timeout got=%b exp=100", {s_err, s_up, s2m[4]}); end
    endtask

    initial begin
        test_reset();
        test_sync();
        test_single();
        test_duplex();
        test_backpressure();
        test_sync_values();
        test_dead_peer();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/comm_link.md
# comm_link

Board-to-board link layer between the `gameVisuals` system's 6-bit communication ports and the GPIO header wired to the opponent board. It runs two independent paths, so the link is full duplex:
- **TX path:** takes nibbles the processor writes on `communication_output` and sends them to the peer with a 4-phase strobe/ack handshake.
- **RX path:** takes nibbles the peer sends and presents them on `communication_input` with a matching level handshake.

After reset it performs a one-time master/slave sync exchange, times out dead peers, and reports link status.

## Interface
- `SYNC_STAGES`, default 2: flip-flop stages on `link_in`, minimum 2.
- `TIMEOUT_CYCLES`, default 50_000_000: cycles a TX wire handshake may stall before the link is declared dead (1 s at 50 MHz).
- `clk_clk`  in  1  system clock; all logic on the rising edge.
- `reset_reset_n`  in  1  reset, synchronous, active-low.
- `masterslave_ismaster`  in  1  selects the sync role; must be static while out of reset.
- `sys_tx`  in  6  from `communication_output`: [3:0] tx nibble, [4] tx_req, [5] rx_ack.
- `sys_rx`  out  6  to `communication_input`: [3:0] rx nibble, [4] tx_done, [5] rx_valid.
- `link_out`  out  6  to the peer: [3:0] data, [4] strobe, [5] ack.
- `link_in`  in  6  from the peer, same layout; asynchronous.
- `link_up`  out  1  sync exchange completed.
- `link_err`  out  1  sticky TX timeout.

## Operation
- **Reset values.** All outputs are 0, synchronizer flops are 0, and both FSMs are in IDLE.
- **Wire protocol (4-phase).**
  - Sender drives data, then raises strobe one cycle later.
  - Receiver captures the synchronized data when the synchronized strobe is 1, then raises ack.
  - Sender drops strobe when it sees ack.
  - Receiver drops ack when it sees strobe low.
  - Sender finishes when it sees ack low.
  - Data is held stable until ack falls.
- **Ownership.** `link_out[4:0]` belong to the TX path; `link_out[5]` belongs to the RX path.
- **TX FSM** (T_IDLE, T_SETUP, T_STROBE, T_RELEASE, T_DONE):
  - T_IDLE → T_SETUP when `link_up & tx_req & !tx_done`. The nibble is latched and driven onto `link_out[3:0]`.
  - T_IDLE → T_SETUP for an internal sync send, which has priority.
  - T_SETUP → T_STROBE: strobe = 1.
  - T_STROBE → T_RELEASE when the synchronized ack = 1: strobe = 0.
  - T_RELEASE → T_DONE when the synchronized ack = 0. For a processor send, `tx_done` = 1. For a sync send, go straight to T_IDLE.
  - T_DONE → T_IDLE when `tx_req` = 0: `tx_done` = 0.
- **RX FSM** (R_IDLE, R_WAITLOW, R_DELIVER, R_ACKLOW):
  - R_IDLE → R_WAITLOW when the synchronized strobe = 1: capture the nibble, ack = 1.
  - R_WAITLOW, when the synchronized strobe = 0: ack = 0.
    - If `link_up`: `rx_valid` = 1 and go to R_DELIVER.
    - Otherwise: run the sync check and go to R_IDLE.
  - R_DELIVER → R_ACKLOW when `rx_ack` = 1: `rx_valid` = 0.
  - R_ACKLOW → R_IDLE when `rx_ack` = 0.
  - Flow control: the peer's next strobe is not serviced until R_IDLE.
- **Sync exchange, master side.**
  - Sends 0xA once per reset.
  - `link_up` = 1 when 0x5 is received.
- **Sync exchange, slave side.**
  - Receiving 0xA while `!link_up` sets reply-pending; TX then sends 0x5.
  - `link_up` = 1 when that 0x5 transfer finishes.
- **Nibbles before `link_up`.** A nibble other than the expected sync value is acked and discarded. While `!link_up`, `tx_req` is ignored.
- **After `link_up`.** All nibbles, including 0xA and 0x5, are user data.
- **Timeout.**
  - The TX counter runs only in T_STROBE and T_RELEASE, and clears on every state entry.
  - Reaching `TIMEOUT_CYCLES` forces `link_err` = 1, `link_up` = 0, strobe = 0, TX → T_IDLE, with no `tx_done` pulse.
  - The link stays down until reset.
- **Reset mid-transfer.** Both FSMs return to IDLE on the next edge and all handshake outputs drop. The peer's timeout handles the abandoned transfer.

## Timing
- `SYNC_STAGES` = 2, two instances cross-connected, `tx_req` sampled high at cycle 0:
  - data visible at cycle 1, strobe at cycle 2;
  - peer ack at cycle 5;
  - strobe low at cycle 8;
  - peer ack low and `rx_valid` at cycle 11;
  - `tx_done` at cycle 14.
- Each additional sync stage adds 4 cycles to `tx_done`.
- `rx_valid` falls 1 cycle after `rx_ack` is sampled high.
- `tx_done` falls 1 cycle after `tx_req` is sampled low.
- Minimum back-to-back period is 15 cycles per nibble plus processor response time.

## Structure
- **Package `comm_link_pkg`:**
  - TX and RX state enums;
  - `SYNC_MASTER` = 4'hA, `SYNC_SLAVE` = 4'h5;
  - bit-index constants for the data, strobe, ack, tx_req, rx_ack, tx_done and rx_valid fields.
- **Sub-module `comm_link_sync`:** parameterized width × stages synchronizer, instantiated once on `link_in`.
- Counter width is `$clog2(TIMEOUT_CYCLES+1)`.

## Test plan
- **Sync exchange.** Two instances (master/slave) cross-connected, released from reset → both `link_up` = 1 after two transfers; no `sys_rx` activity.
- **Single transfer.** After `link_up`, master sends 0x3 → slave `rx_valid` = 1 with `sys_rx[3:0]` = 3 at cycle 11, master `tx_done` at cycle 14.
- **Full duplex and backpressure.** Both sides send simultaneously (0x7 and 0xC) → each receives the other's nibble, no corruption. Slave holds `rx_ack` = 0 for 100 cycles while the master queues a second nibble → the second strobe is not acked until the slave's RX returns to R_IDLE.
- **Dead peer.** `link_in` tied to 0, `TIMEOUT_CYCLES` = 100 → master `link_err` = 1 and strobe = 0 at about cycle 102; `tx_req` is then ignored.
- **Reset mid-transfer.** Reset asserted while strobe = 1 → `link_out` = 0 next edge. The peer times out, then `link_err` = 1 on the peer.
- **Sync values as data.** 0xA and 0x5 sent after `link_up` → delivered as ordinary data.
